// File: rtl/game_turn_controller.sv
// Connect-Four match sequencer: owns the board, takes human moves over a
// valid/ready handshake, launches one tree search per AI turn and applies
// its result, then reports wins and draws to the display stage.
//
// Handshake: a human move is taken on any cycle where i_move_valid and
// o_move_ready are both high. o_move_ready depends only on the state.
// An illegal column produces a registered one-cycle o_move_reject on the
// following cycle, and the controller keeps waiting.
module game_turn_controller #(
  parameter int ROWS     = 6,
  parameter int COLS     = 7,
  parameter bit AI_FIRST = 1'b0
) (
  input  logic                   w_clk,
  input  logic                   w_rst_n,
  input  logic                   i_new_game,
  input  logic                   i_move_valid,
  input  logic [2:0]             i_move_col,
  output logic                   o_move_ready,
  output logic                   o_move_reject,
  output logic                   o_search_en,
  input  logic                   i_search_finished,
  input  logic [2:0]             i_search_col,
  output logic [ROWS*COLS-1:0]   o_me_field,
  output logic [ROWS*COLS-1:0]   o_op_field,
  output logic [3*COLS-1:0]      o_piled_array,
  output logic                   o_ai_thinking,
  output logic [2:0]             o_last_ai_col,
  output logic [1:0]             o_result
);

  localparam int CELLS = ROWS * COLS;
  localparam int CW    = $clog2(CELLS + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(CELLS);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_HUMAN, S_PLACE_OP, S_CHECK_OP, S_SEARCH_START,
    S_SEARCH_WAIT, S_PLACE_ME, S_CHECK_ME, S_GAME_OVER
  } state_t;

  state_t              r_state, w_next;
  logic [CELLS-1:0]    r_me, r_op;
  logic [3*COLS-1:0]   r_piled;
  logic [CW-1:0]       r_count;
  logic [2:0]          r_col;       // column latched from human or tree
  logic [2:0]          r_last_ai;
  logic [1:0]          r_result;
  logic                r_reject;

  logic                w_clear, w_accept, w_reject, w_latch_ai, w_set_result;
  logic [1:0]          w_result_val;
  logic                w_human_legal, w_op_win, w_me_win;
  logic [2:0]          w_fallback, w_ai_col;

  function automatic logic [2:0] height_of(input logic [3*COLS-1:0] piled,
                                           input logic [2:0] col);
    logic [2:0] h;
    h = '0;
    for (int c = 0; c < COLS; c++)
      if (col == 3'(c)) h = piled[3*c +: 3];
    return h;
  endfunction

  function automatic logic col_legal(input logic [3*COLS-1:0] piled,
                                     input logic [2:0] col);
    return (int'(col) < COLS) && (int'(height_of(piled, col)) < ROWS);
  endfunction

  // Writes only cells that exist; a full column leaves the field untouched.
  function automatic logic [CELLS-1:0] set_cell(input logic [CELLS-1:0] f,
                                                input logic [2:0] col,
                                                input logic [2:0] h);
    logic [CELLS-1:0] n;
    n = f;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (col == 3'(c) && h == 3'(r)) n[c*ROWS + r] = 1'b1;
    return n;
  endfunction

  // Height increment that saturates at ROWS.
  function automatic logic [3*COLS-1:0] bump(input logic [3*COLS-1:0] piled,
                                             input logic [2:0] col);
    logic [3*COLS-1:0] n;
    n = piled;
    for (int c = 0; c < COLS; c++)
      if (col == 3'(c) && int'(piled[3*c +: 3]) < ROWS)
        n[3*c +: 3] = piled[3*c +: 3] + 3'd1;
    return n;
  endfunction

  // Four in a row in any direction; loop bounds keep every index on the board.
  function automatic logic has_four(input logic [CELLS-1:0] f);
    logic w;
    w = 1'b0;
    for (int c = 0; c < COLS - 3; c++)
      for (int r = 0; r < ROWS; r++)
        if (f[c*ROWS+r] && f[(c+1)*ROWS+r] && f[(c+2)*ROWS+r] && f[(c+3)*ROWS+r]) w = 1'b1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS - 3; r++)
        if (f[c*ROWS+r] && f[c*ROWS+r+1] && f[c*ROWS+r+2] && f[c*ROWS+r+3]) w = 1'b1;
    for (int c = 0; c < COLS - 3; c++)
      for (int r = 0; r < ROWS - 3; r++) begin
        if (f[c*ROWS+r] && f[(c+1)*ROWS+r+1] && f[(c+2)*ROWS+r+2] && f[(c+3)*ROWS+r+3]) w = 1'b1;
        if (f[c*ROWS+r+3] && f[(c+1)*ROWS+r+2] && f[(c+2)*ROWS+r+1] && f[(c+3)*ROWS+r]) w = 1'b1;
      end
    return w;
  endfunction

  // Move legality, win detection and the AI column with full-column fallback.
  always_comb begin
    w_human_legal = col_legal(r_piled, i_move_col);
    w_op_win      = has_four(r_op);
    w_me_win      = has_four(r_me);
    w_fallback    = '0;
    for (int c = COLS - 1; c >= 0; c--)
      if (int'(r_piled[3*c +: 3]) < ROWS) w_fallback = 3'(c);
    w_ai_col = col_legal(r_piled, r_col) ? r_col : w_fallback;
  end

  // State register.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and datapath control decode.
  always_comb begin
    w_next       = r_state;
    w_clear      = 1'b0;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_latch_ai   = 1'b0;
    w_set_result = 1'b0;
    w_result_val = 2'b00;
    case (r_state)
      S_IDLE, S_GAME_OVER: begin
        if (i_new_game) begin
          w_clear = 1'b1;
          w_next  = AI_FIRST ? S_SEARCH_START : S_WAIT_HUMAN;
        end
      end
      S_WAIT_HUMAN: begin
        if (i_new_game) begin
          w_clear = 1'b1;
          w_next  = AI_FIRST ? S_SEARCH_START : S_WAIT_HUMAN;
        end else if (i_move_valid) begin
          if (w_human_legal) begin
            w_accept = 1'b1;
            w_next   = S_PLACE_OP;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      S_PLACE_OP: w_next = S_CHECK_OP;
      S_CHECK_OP: begin
        if (w_op_win) begin
          w_set_result = 1'b1;
          w_result_val = 2'b10;
          w_next       = S_GAME_OVER;
        end else if (r_count == FULL_COUNT) begin
          w_set_result = 1'b1;
          w_result_val = 2'b11;
          w_next       = S_GAME_OVER;
        end else begin
          w_next = S_SEARCH_START;
        end
      end
      S_SEARCH_START: w_next = S_SEARCH_WAIT;
      S_SEARCH_WAIT: begin
        if (i_search_finished) begin
          w_latch_ai = 1'b1;
          w_next     = S_PLACE_ME;
        end
      end
      S_PLACE_ME: w_next = S_CHECK_ME;
      S_CHECK_ME: begin
        if (w_me_win) begin
          w_set_result = 1'b1;
          w_result_val = 2'b01;
          w_next       = S_GAME_OVER;
        end else if (r_count == FULL_COUNT) begin
          w_set_result = 1'b1;
          w_result_val = 2'b11;
          w_next       = S_GAME_OVER;
        end else begin
          w_next = S_WAIT_HUMAN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Board, counter, latched column and result registers.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_me      <= '0;
      r_op      <= '0;
      r_piled   <= '0;
      r_count   <= '0;
      r_col     <= '0;
      r_last_ai <= '0;
      r_result  <= 2'b00;
      r_reject  <= 1'b0;
    end else begin
      r_reject <= w_reject;
      if (w_clear) begin
        r_me      <= '0;
        r_op      <= '0;
        r_piled   <= '0;
        r_count   <= '0;
        r_last_ai <= '0;
        r_result  <= 2'b00;
      end else begin
        if (w_accept)   r_col <= i_move_col;
        if (w_latch_ai) r_col <= i_search_col;
        if (r_state == S_PLACE_OP) begin
          r_op    <= set_cell(r_op, r_col, height_of(r_piled, r_col));
          r_piled <= bump(r_piled, r_col);
          if (r_count != FULL_COUNT) r_count <= r_count + CW'(1);
        end
        if (r_state == S_PLACE_ME) begin
          r_me      <= set_cell(r_me, w_ai_col, height_of(r_piled, w_ai_col));
          r_piled   <= bump(r_piled, w_ai_col);
          r_last_ai <= w_ai_col;
          if (r_count != FULL_COUNT) r_count <= r_count + CW'(1);
        end
        if (w_set_result) r_result <= w_result_val;
      end
    end
  end

  assign o_move_ready  = (r_state == S_WAIT_HUMAN);
  assign o_move_reject = r_reject;
  assign o_search_en   = (r_state == S_SEARCH_START);
  assign o_ai_thinking = (r_state == S_SEARCH_START) || (r_state == S_SEARCH_WAIT) ||
                         (r_state == S_PLACE_ME);
  assign o_me_field    = r_me;
  assign o_op_field    = r_op;
  assign o_piled_array = r_piled;
  assign o_last_ai_col = r_last_ai;
  assign o_result      = r_result;

endmodule

// File: tb/tb_game_turn_controller.sv
// Bench for game_turn_controller: a stub search tree answers each launch,
// a small board model tracks expected fields, and a table of 21 rounds
// plays a full drawn game.
module tb_game_turn_controller;

  localparam int ROWS  = 6;
  localparam int COLS  = 7;
  localparam int CELLS = ROWS * COLS;

  logic               w_clk = 1'b0;
  logic               w_rst_n = 1'b0;
  logic               i_new_game = 1'b0;
  logic               i_move_valid = 1'b0;
  logic [2:0]         i_move_col = '0;
  logic               o_move_ready, o_move_reject, o_search_en;
  logic               i_search_finished = 1'b0;
  logic [2:0]         i_search_col = '0;
  logic [CELLS-1:0]   o_me_field, o_op_field;
  logic [3*COLS-1:0]  o_piled_array;
  logic               o_ai_thinking;
  logic [2:0]         o_last_ai_col;
  logic [1:0]         o_result;

  game_turn_controller #(.ROWS(ROWS), .COLS(COLS), .AI_FIRST(1'b0)) dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n), .i_new_game(i_new_game),
    .i_move_valid(i_move_valid), .i_move_col(i_move_col),
    .o_move_ready(o_move_ready), .o_move_reject(o_move_reject),
    .o_search_en(o_search_en), .i_search_finished(i_search_finished),
    .i_search_col(i_search_col), .o_me_field(o_me_field),
    .o_op_field(o_op_field), .o_piled_array(o_piled_array),
    .o_ai_thinking(o_ai_thinking), .o_last_ai_col(o_last_ai_col),
    .o_result(o_result)
  );

  // Clock and search-launch counter.
  always #5 w_clk = ~w_clk;

  int se_count = 0;
  always @(posedge w_clk) if (o_search_en) se_count <= se_count + 1;

  // Scoreboard state and board model.
  int               n_checks = 0;
  int               n_errors = 0;
  logic [2:0]       exp_q[$];
  logic [CELLS-1:0] m_me, m_op;
  int               m_h[COLS];

  typedef struct {
    int hcol;
    int ai_col;
    int exp_land;
    int exp_res;
  } vec_t;
  vec_t vecs[21];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  function automatic logic [3*COLS-1:0] m_piled();
    logic [3*COLS-1:0] p;
    p = '0;
    for (int c = 0; c < COLS; c++) p[3*c +: 3] = 3'(m_h[c]);
    return p;
  endfunction

  task automatic m_clear();
    m_me = '0;
    m_op = '0;
    for (int c = 0; c < COLS; c++) m_h[c] = 0;
  endtask

  task automatic m_place(input bit is_me, input int col);
    int idx;
    idx = col * ROWS + m_h[col];
    if (is_me) m_me[idx] = 1'b1;
    else       m_op[idx] = 1'b1;
    m_h[col]++;
  endtask

  task automatic check_board(input string tag);
    check({tag, " me_field"}, o_me_field, m_me);
    check({tag, " op_field"}, o_op_field, m_op);
    check({tag, " piled"}, o_piled_array, m_piled());
  endtask

  // Drivers.
  task automatic new_game();
    i_new_game = 1'b1;
    tick();
    i_new_game = 1'b0;
    m_clear();
    check("new_game ready", o_move_ready, 1);
    check("new_game result", o_result, 0);
    check("new_game search_en", o_search_en, 0);
    check_board("new_game");
  endtask

  // Leaves the bench in the cycle after the handshake cycle.
  task automatic human_move(input int col);
    int n;
    n = 0;
    while (!o_move_ready && n < 50) begin
      tick();
      n++;
    end
    check("ready before move", o_move_ready, 1);
    i_move_valid = 1'b1;
    i_move_col   = 3'(col);
    tick();
    i_move_valid = 1'b0;
  endtask

  task automatic reject_move(input int col);
    human_move(col);
    check("reject pulse", o_move_reject, 1);
    check("ready during reject", o_move_ready, 1);
    check_board("after reject");
    tick();
    check("reject one cycle", o_move_reject, 0);
    check("ready after reject", o_move_ready, 1);
  endtask

  // One human move, then the stub tree answers ai_ret after 'delay' wait cycles.
  task automatic play_round(input int hcol, input int ai_ret, input int exp_land,
                            input int exp_res, input int delay, input bit poke);
    int se0;
    bit bad;
    human_move(hcol);
    m_place(1'b0, hcol);
    se0 = se_count;
    check("search_en cycle1", o_search_en, 0);
    tick();
    check("search_en cycle2", o_search_en, 0);
    check_board("after human");
    tick();
    check("search_en cycle3", o_search_en, 1);
    check("thinking at launch", o_ai_thinking, 1);
    bad = 1'b0;
    for (int d = 0; d < delay; d++) begin
      tick();
      if (o_ai_thinking !== 1'b1 || o_search_en !== 1'b0 || o_move_ready !== 1'b0) bad = 1'b1;
      i_new_game = (poke && d == 0);
    end
    check("wait outputs", bad, 0);
    i_search_finished = 1'b1;
    i_search_col      = 3'(ai_ret);
    exp_q.push_back(3'(exp_land));
    tick();
    i_search_finished = 1'b0;
    i_new_game        = 1'b0;
    check("single launch", se_count - se0, 1);
    check("thinking place_me", o_ai_thinking, 1);
    tick();
    m_place(1'b1, exp_land);
    check("last_ai_col", o_last_ai_col, exp_q.pop_front());
    check("thinking dropped", o_ai_thinking, 0);
    check_board("after ai");
    tick();
    if (exp_res == 0) check("ready after ai", o_move_ready, 1);
    else              check("ready at game end", o_move_ready, 0);
    check("result after round", o_result, exp_res);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int xc[3];
    int yc[3];
    int k;
    int se0;

    // Drawn game: X columns stack h,a,h,... and Y columns a,h,a,...;
    // layout X X Y Y X X Y has no four in any direction.
    xc = '{0, 1, 4};
    yc = '{2, 3, 6};
    k = 0;
    for (int p = 0; p < 3; p++)
      for (int r = 0; r < ROWS; r++) begin
        if (r % 2 == 0) vecs[k] = '{xc[p], yc[p], yc[p], 0};
        else            vecs[k] = '{yc[p], xc[p], xc[p], 0};
        k++;
      end
    for (int r = 0; r < 3; r++) begin
      vecs[k] = '{5, 5, 5, 0};
      k++;
    end
    vecs[20].exp_res = 3;

    // Reset.
    m_clear();
    w_rst_n = 1'b0;
    repeat (3) @(posedge w_clk);
    #1;
    check("reset ready", o_move_ready, 0);
    check("reset search_en", o_search_en, 0);
    check("reset thinking", o_ai_thinking, 0);
    check("reset result", o_result, 0);
    check("reset last_ai", o_last_ai_col, 0);
    check_board("reset");
    w_rst_n = 1'b1;
    tick();
    check("idle not ready", o_move_ready, 0);

    // First move pair with a slow tree.
    new_game();
    play_round(3, 2, 2, 0, 10, 1'b0);
    check("op bit 18", o_op_field[18], 1);
    check("me bit 12", o_me_field[12], 1);
    check("height col2", o_piled_array[8:6], 1);
    check("height col3", o_piled_array[11:9], 1);

    // Fill column 0, then illegal offers.
    for (int i = 0; i < 3; i++) play_round(0, 0, 0, 0, $urandom_range(1, 5), 1'b0);
    reject_move(0);
    reject_move(7);

    // Tree answers: full column, free column, out-of-range column.
    play_round(3, 0, 1, 0, 2, 1'b0);
    play_round(4, 5, 5, 0, 3, 1'b0);
    play_round(6, 7, 1, 0, 3, 1'b1);

    // Human vertical win in column 0.
    new_game();
    for (int i = 0; i < 3; i++) play_round(0, 6, 6, 0, $urandom_range(1, 4), 1'b0);
    human_move(0);
    m_place(1'b0, 0);
    se0 = se_count;
    tick();
    tick();
    check("human win result", o_result, 2);
    check("game over not ready", o_move_ready, 0);
    check("game over thinking", o_ai_thinking, 0);
    check_board("human win");
    repeat (20) tick();
    check("no search after win", se_count - se0, 0);
    check("board frozen", o_op_field, m_op);

    // Full 42-stone drawn game.
    new_game();
    for (int i = 0; i < 21; i++)
      play_round(vecs[i].hcol, vecs[i].ai_col, vecs[i].exp_land, vecs[i].exp_res,
                 $urandom_range(1, 4), 1'b0);

    // Reset during a search.
    new_game();
    human_move(3);
    tick();
    tick();
    tick();
    check("thinking before reset", o_ai_thinking, 1);
    #2;
    w_rst_n = 1'b0;
    #1;
    m_clear();
    check("async reset thinking", o_ai_thinking, 0);
    check("async reset search_en", o_search_en, 0);
    check("async reset ready", o_move_ready, 0);
    check("async reset reject", o_move_reject, 0);
    check("async reset result", o_result, 0);
    check("async reset last_ai", o_last_ai_col, 0);
    check_board("async reset");
    tick();
    w_rst_n = 1'b1;
    tick();
    check("idle after reset", o_move_ready, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/game_turn_controller.md
Name: game_turn_controller

Overview:
- Sequences a Connect-Four match between a human player and the search tree.
- Owns the authoritative board: me (AI) field, op (human) field and piled-count array.
- Accepts human moves through a valid/ready handshake and launches one search per AI turn, feeding the tree's w_en, i_me_field, i_op_field and i_piled_array.
- Applies the tree's o_selected_col result, detects wins and draws, and exposes board and status to the display stage.

Parameters:
- ROWS, 6, rows per column; field bit index = col*ROWS + row, row 0 = bottom.
- COLS, 7, column count; legal columns are 0..COLS-1.
- AI_FIRST, 0, 1 = AI moves first after new game.

Ports:
- w_clk  in  1  system clock
- w_rst_n  in  1  asynchronous active-low reset
- i_new_game  in  1  1-cycle pulse: clear board, start match
- i_move_valid  in  1  human move offered
- i_move_col  in  3  human column
- o_move_ready  out  1  high only in WAIT_HUMAN
- o_move_reject  out  1  1-cycle pulse: offered column illegal (>=COLS or full)
- o_search_en  out  1  1-cycle pulse to tree w_en
- i_search_finished  in  1  tree o_finished (1-cycle pulse)
- i_search_col  in  3  tree o_selected_col
- o_me_field  out  ROWS*COLS  AI stones, to tree and display
- o_op_field  out  ROWS*COLS  human stones
- o_piled_array  out  3*COLS  stack height per column, column c at bits [3c+2:3c]
- o_ai_thinking  out  1  high from search launch until result applied
- o_last_ai_col  out  3  column of last AI move
- o_result  out  2  00 playing, 01 AI won, 10 human won, 11 draw

Behaviour:
- Reset (async, w_rst_n low): all fields, piled array and move counter are 0; state IDLE; all outputs 0; o_result 00.
- States:
  - IDLE: entered only via reset; i_new_game leaves it.
  - WAIT_HUMAN
  - PLACE_OP
  - CHECK_OP
  - SEARCH_START
  - SEARCH_WAIT
  - PLACE_ME
  - CHECK_ME
  - GAME_OVER
- i_new_game in IDLE, WAIT_HUMAN or GAME_OVER:
  - Clears board, counter and o_result.
  - Goes next cycle to SEARCH_START if AI_FIRST, else WAIT_HUMAN.
  - Ignored in any other state; the tree has no abort.
- WAIT_HUMAN, handshake completes when i_move_valid & o_move_ready:
  - Column legal (col<COLS and height<ROWS): latch column, go to PLACE_OP.
  - Column illegal: pulse o_move_reject for 1 cycle and stay in WAIT_HUMAN; board unchanged.
- PLACE_OP (1 cycle): set op bit col*ROWS+height, increment that column's height, increment move counter.
- CHECK_OP (1 cycle), four-in-a-row checked on the registered op field (horizontal, vertical, both diagonals):
  - Win: o_result=10, go to GAME_OVER.
  - Else if counter==ROWS*COLS: o_result=11, go to GAME_OVER.
  - Else go to SEARCH_START.
- SEARCH_START (1 cycle): o_search_en=1, o_ai_thinking=1, go to SEARCH_WAIT.
- SEARCH_WAIT:
  - Board outputs held bit-stable for the whole wait; the tree re-samples them every cycle.
  - On i_search_finished: latch i_search_col, go to PLACE_ME.
  - No timeout.
- PLACE_ME (1 cycle):
  - Latched column legal: use it.
  - Latched column illegal (>=COLS or full): substitute the lowest-index non-full column.
  - Set me bit, increment that column's height and the counter, o_last_ai_col = used column.
  - o_ai_thinking drops at the end of this cycle.
- CHECK_ME (1 cycle):
  - Win: o_result=01, go to GAME_OVER.
  - Else if counter full: o_result=11, go to GAME_OVER.
  - Else go to WAIT_HUMAN.
- GAME_OVER: board frozen; o_move_ready=0; only i_new_game leaves.
- Latency:
  - Accepted human move to o_search_en: 3 cycles.
  - i_search_finished to o_move_ready: 3 cycles.
- Heights saturate at ROWS; no field bit outside 0..ROWS*COLS-1 is ever written.
- Reset asserted mid-search returns to IDLE immediately; the tree must share the reset domain.

Test Plan:
- Reset, then i_new_game with AI_FIRST=0 -> o_move_ready=1 next cycle; fields 0; o_result=00.
- Human col 3 offered; stub tree finishes after 10 cycles with col 2 -> o_search_en pulses exactly once 3 cycles after accept; op bit 18 and me bit 12 set; piled heights col2=1, col3=1; o_last_ai_col=2; o_ai_thinking high for the whole wait.
- Fill col 0 (6 stones), then human offers col 0, then col 7 -> o_move_reject pulses each time; board unchanged; o_move_ready stays 1.
- Human plays col 0 four times while stub AI always plays col 6 -> after 4th human stone, o_result=10, no 4th search launched, o_move_ready=0.
- Stub tree returns col 0 with col 0 full -> AI stone lands in col 1.
- Stub tree returns col 5 while col 5 is free -> stone lands in col 5, no substitution.
- Scripted 42-move game with no line -> o_result=11 after 42nd stone.
- Assert w_rst_n low during SEARCH_WAIT -> all outputs 0 asynchronously.
- i_new_game pulsed during SEARCH_WAIT -> ignored, board intact.
